// File: rtl/seq_pkg.sv
// Shared widths and FSM state encodings for the pattern generator and the M/N detector.
package seq_pkg;

  localparam int DEF_N_W   = 6;
  localparam int DEF_M_W   = 5;
  localparam int DEF_GAP_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_LOW  = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

endpackage

// File: rtl/seq_run_counter.sv
// Loadable down-counter; tc flags the final cycle of a loaded run.
module seq_run_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial M x (N ones, N zeros) burst source with optional idle gap and start/busy/done handshake.
// Optional macro SEQ_GEN_ERR_INJECT_EN adds err_pair to shorten one pair's LOW run.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int N_W   = DEF_N_W,
  parameter int M_W   = DEF_M_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   N,
  input  logic [M_W-1:0]   M,
  input  logic [GAP_W-1:0] gap,
`ifdef SEQ_GEN_ERR_INJECT_EN
  input  logic [M_W-1:0]   err_pair,
`endif
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic [M_W-1:0]   pair_idx
);

  state_t           state, state_n;
  logic [N_W-1:0]   n_q;
  logic [M_W-1:0]   m_q;
  logic [GAP_W-1:0] gap_q;
  logic [M_W-1:0]   pair_n;
  logic             done_n, accept, low_end;
  logic             run_load, run_en, run_tc;
  logic [N_W-1:0]   run_val, low_len;
  logic             gap_load, gap_en, gap_tc;
  logic             err_hit;

`ifdef SEQ_GEN_ERR_INJECT_EN
  assign err_hit = (err_pair != '0) && (pair_idx == err_pair);
`else
  assign err_hit = 1'b0;
`endif

  assign low_len = err_hit ? (n_q - 1'b1) : n_q;

  // A zero-length LOW run (err injection with N=1) falls straight into the pair-end decision.
  always_comb begin
    state_n  = state;
    pair_n   = pair_idx;
    done_n   = 1'b0;
    accept   = 1'b0;
    low_end  = 1'b0;
    run_load = 1'b0;
    run_en   = 1'b0;
    run_val  = n_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if ((N != '0) && (M != '0)) begin
            accept   = 1'b1;
            state_n  = ST_HIGH;
            pair_n   = M_W'(1);
            run_load = 1'b1;
            run_val  = N;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (run_tc) begin
          if (low_len != '0) begin
            state_n  = ST_LOW;
            run_load = 1'b1;
            run_val  = low_len;
          end else begin
            low_end = 1'b1;
          end
        end else begin
          run_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (run_tc) low_end = 1'b1;
        else        run_en  = 1'b1;
      end
      ST_GAP: begin
        if (gap_tc) begin
          state_n = ST_IDLE;
          pair_n  = '0;
          done_n  = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (low_end) begin
      if (pair_idx < m_q) begin
        state_n  = ST_HIGH;
        pair_n   = pair_idx + 1'b1;
        run_load = 1'b1;
        run_val  = n_q;
      end else if (gap_q != '0) begin
        state_n  = ST_GAP;
        gap_load = 1'b1;
      end else begin
        state_n = ST_IDLE;
        pair_n  = '0;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      m_q      <= '0;
      gap_q    <= '0;
      data_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pair_idx <= '0;
    end else begin
      state    <= state_n;
      data_out <= (state_n == ST_HIGH);
      busy     <= (state_n != ST_IDLE);
      done     <= done_n;
      pair_idx <= pair_n;
      if (accept) begin
        n_q   <= N;
        m_q   <= M;
        gap_q <= gap;
      end
    end
  end

  seq_run_counter #(.W(N_W)) u_run_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (run_load),
    .en       (run_en),
    .load_val (run_val),
    .tc       (run_tc)
  );

  seq_run_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (gap_q),
    .tc       (gap_tc)
  );

endmodule
